im_boot_loader: RTL and testbench

- Upstream of the multicycle MIPS core.
- Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them sequentially into the instruction memory through a write port.
- Holds the core in reset until a complete image with a valid checksum has been loaded, then releases it.
- On a bad image, keeps the core in reset and flags an error.

---
 rtl/im_boot_loader_pkg.sv | 19 +
 rtl/im_boot_loader_packer.sv | 40 ++++
 rtl/im_boot_loader.sv | 175 +++++++++++++++++
 tb/tb_im_boot_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/im_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding and error-code values.
package boot_defs;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } bootState_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SIZE = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/im_boot_loader_packer.sv
// Assembles big-endian 32-bit words from a byte stream; flags a
// registered one-cycle wordValid after each fourth byte.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shiftEn,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic        wordValid,
  output logic        lastByte
);

  logic [1:0]  byteCnt;
  logic [23:0] shReg;

  assign lastByte = shiftEn & (byteCnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byteCnt   <= 2'd0;
      shReg     <= 24'd0;
      word      <= 32'd0;
      wordValid <= 1'b0;
    end else if (clear) begin
      byteCnt   <= 2'd0;
      shReg     <= 24'd0;
      wordValid <= 1'b0;
    end else begin
      wordValid <= lastByte;
      if (shiftEn) begin
        byteCnt <= byteCnt + 2'd1;
        shReg   <= {shReg[15:0], byteIn};
        // word is held between writes so im_wdata stays stable
        if (lastByte) word <= {shReg, byteIn};
      end
    end
  end

endmodule

// File: rtl/im_boot_loader.sv
// Boot loader: receives a word-count header, data words and an XOR checksum
// over a byte stream, writes the instruction memory and releases the core.
//
// state  | meaning
// HDR_HI | waiting for word count high byte (never times out)
// HDR_LO | waiting for word count low byte; size check
// DATA   | receiving 4N data bytes, writing words
// CSUM   | waiting for checksum byte
// DONE   | image verified, core released
// ERR    | load failed, core held in reset
module im_boot_loader
  import boot_defs::*;
#(
  parameter int IM_ADDR_W   = 10,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 reload,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [31:0]          im_wdata,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] IM_DEPTH = 17'(2 ** IM_ADDR_W);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);

  bootState_t state, stateNxt;
  logic [1:0]           errCodeQ, errCodeNxt;
  logic                 readyEn;
  logic                 accept, reloadTake, shiftEn, idleHit, counting;
  logic                 packLast, wordValid, lastWord;
  logic [15:0]          wordCnt;
  logic [16:0]          nFull;
  logic [IM_ADDR_W:0]   wordIdx;
  logic [IM_ADDR_W-1:0] imAddrQ;
  logic [7:0]           csum;
  logic [IDLE_W-1:0]    idleCnt;
  logic [31:0]          packWord;

  assign in_ready   = readyEn & ((state == HDR_HI) | (state == HDR_LO) |
                                 (state == DATA)   | (state == CSUM));
  assign accept     = in_valid & in_ready;
  assign shiftEn    = accept & (state == DATA);
  assign reloadTake = reload & ((state == DONE) | (state == ERR));
  assign counting   = (state == HDR_LO) | (state == DATA) | (state == CSUM);
  assign idleHit    = (idleCnt == IDLE_LAST);
  assign nFull      = {1'b0, wordCnt[15:8], in_data};
  assign lastWord   = ((17'(wordIdx) + 17'd1) == {1'b0, wordCnt});

  byte_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (reloadTake),
    .shiftEn   (shiftEn),
    .byteIn    (in_data),
    .word      (packWord),
    .wordValid (wordValid),
    .lastByte  (packLast)
  );

  assign im_we    = wordValid;
  assign im_wdata = packWord;
  assign im_addr  = imAddrQ;
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  assign cpu_rst  = (state != DONE);
  assign err_code = errCodeQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HDR_HI;
      errCodeQ <= ERR_NONE;
      readyEn  <= 1'b0;
    end else begin
      state    <= stateNxt;
      errCodeQ <= errCodeNxt;
      readyEn  <= 1'b1;
    end
  end

  always_comb begin
    stateNxt   = state;
    errCodeNxt = errCodeQ;
    unique case (state)
      HDR_HI: begin
        if (accept) stateNxt = HDR_LO;
      end
      HDR_LO: begin
        if (accept) begin
          if (nFull > IM_DEPTH) begin
            stateNxt   = ERR;
            errCodeNxt = ERR_SIZE;
          end else if (nFull == 17'd0) begin
            stateNxt = CSUM;
          end else begin
            stateNxt = DATA;
          end
        end else if (idleHit) begin
          stateNxt   = ERR;
          errCodeNxt = ERR_TMO;
        end
      end
      DATA: begin
        if (accept) begin
          if (packLast && lastWord) stateNxt = CSUM;
        end else if (idleHit) begin
          stateNxt   = ERR;
          errCodeNxt = ERR_TMO;
        end
      end
      CSUM: begin
        if (accept) begin
          if (in_data == csum) begin
            stateNxt = DONE;
          end else begin
            stateNxt   = ERR;
            errCodeNxt = ERR_CSUM;
          end
        end else if (idleHit) begin
          stateNxt   = ERR;
          errCodeNxt = ERR_TMO;
        end
      end
      DONE, ERR: begin
        if (reload) begin
          stateNxt   = HDR_HI;
          errCodeNxt = ERR_NONE;
        end
      end
      default: begin
        stateNxt = HDR_HI;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wordCnt <= 16'd0;
      wordIdx <= '0;
      imAddrQ <= '0;
      csum    <= 8'd0;
      idleCnt <= '0;
    end else if (reloadTake) begin
      wordCnt <= 16'd0;
      wordIdx <= '0;
      csum    <= 8'd0;
      idleCnt <= '0;
    end else begin
      if (accept && state == HDR_HI) wordCnt[15:8] <= in_data;
      if (accept && state == HDR_LO) wordCnt[7:0]  <= in_data;
      if (shiftEn) csum <= csum ^ in_data;
      // address is latched with the fourth byte so it lines up with im_we
      if (packLast) begin
        imAddrQ <= wordIdx[IM_ADDR_W-1:0];
        wordIdx <= wordIdx + 1'b1;
      end
      if (accept) begin
        idleCnt <= '0;
      end else if (counting && idleCnt != IDLE_MAX) begin
        idleCnt <= idleCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed bench for im_boot_loader with a 4-word memory and a 16-cycle
// idle timeout; expected values are hand-computed constants.
module tb_im_boot_loader;

  localparam int AW  = 2;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          reload;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  int nCompared   = 0;
  int nMismatched = 0;
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];

  im_boot_loader #(.IM_ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .reload   (reload),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wrAddrQ.push_back(32'(im_addr));
      wrDataQ.push_back(im_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulseReload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic chkWrite(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
    if (i < wrAddrQ.size()) begin
      chk({tag, "_addr"}, wrAddrQ[i], a);
      chk({tag, "_data"}, wrDataQ[i], d);
    end else begin
      chk({tag, "_missing"}, 32'(wrAddrQ.size()), 32'(i + 1));
    end
  endtask

  // Good two-word image; checksum = 24^08^00^05^00^00^00^0C = 0x25
  task automatic sendImageA(input logic [7:0] ck);
    sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h24); sendByte(8'h08); sendByte(8'h00); sendByte(8'h05);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h0C);
    sendByte(ck);
  endtask

  initial begin
    logic [31:0] w4 [4];
    logic [31:0] w;
    w4[0] = 32'h11223344; w4[1] = 32'hA5A5A5A5;
    w4[2] = 32'h00000001; w4[3] = 32'hDEADBEEF;

    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; reload = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_im_we",    32'(im_we),    32'd0);
    chk("rst_im_addr",  32'(im_addr),  32'd0);
    chk("rst_im_wdata", im_wdata,      32'd0);
    chk("rst_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("first_cycle_ready", 32'(in_ready), 32'd0);

    // Long idle before the header is not a timeout
    repeat (100) @(posedge clk);
    #1;
    chk("hdr_idle_err",   32'(err),      32'd0);
    chk("hdr_idle_ready", 32'(in_ready), 32'd1);

    // Basic image, valid held high
    wrAddrQ.delete(); wrDataQ.delete();
    sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h24); sendByte(8'h08); sendByte(8'h00); sendByte(8'h05);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h0C);
    chk("pre_csum_done", 32'(done), 32'd0);
    sendByte(8'h25);
    chk("a_done",    32'(done),    32'd1);
    chk("a_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("a_ready",   32'(in_ready), 32'd0);
    chk("a_nwr", 32'(wrAddrQ.size()), 32'd2);
    chkWrite("a_w0", 0, 32'd0, 32'h24080005);
    chkWrite("a_w1", 1, 32'd1, 32'h0000000C);

    pulseReload();
    chk("rl_done",    32'(done),     32'd0);
    chk("rl_cpu_rst", 32'(cpu_rst),  32'd1);
    chk("rl_ready",   32'(in_ready), 32'd1);

    // Bad checksum, then reload and recover
    sendImageA(8'h28);
    chk("bad_err",      32'(err),      32'd1);
    chk("bad_code",     32'(err_code), 32'd2);
    chk("bad_done",     32'(done),     32'd0);
    chk("bad_cpu_rst",  32'(cpu_rst),  32'd1);
    pulseReload();
    chk("bad_rl_err",   32'(err),      32'd0);
    chk("bad_rl_code",  32'(err_code), 32'd0);
    wrAddrQ.delete(); wrDataQ.delete();
    sendImageA(8'h25);
    chk("retry_done", 32'(done), 32'd1);
    chkWrite("retry_w0", 0, 32'd0, 32'h24080005);
    pulseReload();

    // Oversize header: 5 words into a 4-word memory
    wrAddrQ.delete(); wrDataQ.delete();
    sendByte(8'h00); sendByte(8'h05);
    chk("size_err",  32'(err),      32'd1);
    chk("size_code", 32'(err_code), 32'd1);
    repeat (5) @(posedge clk);
    #1 chk("size_nwr", 32'(wrAddrQ.size()), 32'd0);
    pulseReload();

    // Full memory, in_valid toggled; reload mid-image must be ignored.
    // checksum = 0x67
    wrAddrQ.delete(); wrDataQ.delete();
    sendByte(8'h00); @(posedge clk);
    sendByte(8'h04); @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      w = w4[i];
      for (int j = 3; j >= 0; j--) begin
        sendByte(w[j*8 +: 8]);
        @(posedge clk);
      end
      if (i == 0) pulseReload();
    end
    sendByte(8'h67);
    chk("full_done", 32'(done), 32'd1);
    chk("full_nwr",  32'(wrAddrQ.size()), 32'd4);
    for (int i = 0; i < 4; i++) chkWrite($sformatf("full_w%0d", i), i, 32'(i), w4[i]);
    pulseReload();

    // Empty image: header 0, checksum 0
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    chk("empty_done", 32'(done), 32'd1);
    pulseReload();

    // Timeout after two data bytes: 15 idle cycles ok, 16th errors
    sendByte(8'h00); sendByte(8'h01); sendByte(8'h24); sendByte(8'h08);
    repeat (15) @(posedge clk);
    #1 chk("tmo_15_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    chk("tmo_16_err",  32'(err),      32'd1);
    chk("tmo_16_code", 32'(err_code), 32'd3);
    pulseReload();

    // Async reset mid-image, then a clean load from address 0
    sendByte(8'h00); sendByte(8'h01);
    sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready",  32'(in_ready), 32'd0);
    chk("mid_rst_cpu",    32'(cpu_rst),  32'd1);
    chk("mid_rst_addr",   32'(im_addr),  32'd0);
    chk("mid_rst_wdata",  im_wdata,      32'd0);
    @(negedge clk); rst_n = 1'b1;
    wrAddrQ.delete(); wrDataQ.delete();
    sendImageA(8'h25);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_nwr",  32'(wrAddrQ.size()), 32'd2);
    chkWrite("post_rst_w0", 0, 32'd0, 32'h24080005);
    chkWrite("post_rst_w1", 1, 32'd1, 32'h0000000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
